// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port image RAM between requesters A and B
// with round-robin arbitration, optional exclusive lock and tagged read returns.
//
// lock state | meaning
// LOCK_NONE  | no owner, round-robin between A and B
// LOCK_A     | A owns the RAM, only A may be granted
// LOCK_B     | B owns the RAM, only B may be granted
module ram_port_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     reqA,
  input  logic                     reqB,
  input  logic                     wEnA,
  input  logic                     wEnB,
  input  logic [ADDRESS_WIDTH-1:0] addrA,
  input  logic [ADDRESS_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0]    dataInA,
  input  logic [DATA_WIDTH-1:0]    dataInB,
  input  logic                     lockA,
  input  logic                     lockB,
  output logic                     grantA,
  output logic                     grantB,
  output logic                     rdValidA,
  output logic                     rdValidB,
  output logic [DATA_WIDTH-1:0]    rdData,
  output logic                     ramWEn,
  output logic [ADDRESS_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0]    ramDataIn,
  input  logic [DATA_WIDTH-1:0]    ramDataOut
);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_A    = 2'd1,
    LOCK_B    = 2'd2
  } lock_e;

  lock_e                 lock_q, lock_d;
  logic                  last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic                  pend_a_q, pend_a_d;
  logic                  pend_b_q, pend_b_d;
  logic                  rd_valid_a_q, rd_valid_a_d;
  logic                  rd_valid_b_q, rd_valid_b_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  grant_a, grant_b;

  always_comb begin : arbitrate
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (resetN) begin
      case (lock_q)
        LOCK_A: grant_a = reqA;
        LOCK_B: grant_b = reqB;
        default: begin
          if (reqA && reqB) begin
            grant_a = last_grant_q;
            grant_b = ~last_grant_q;
          end else begin
            grant_a = reqA;
            grant_b = reqB;
          end
        end
      endcase
    end
  end

  // With no grant the address/data follow A; harmless since only a read can occur.
  always_comb begin : ram_mux
    ramWEn    = 1'b0;
    ramAddr   = addrA;
    ramDataIn = dataInA;
    if (grant_b) begin
      ramWEn    = wEnB;
      ramAddr   = addrB;
      ramDataIn = dataInB;
    end else if (grant_a) begin
      ramWEn    = wEnA;
    end
  end

  always_comb begin : next_state
    last_grant_d = last_grant_q;
    if (grant_a) last_grant_d = 1'b0;
    if (grant_b) last_grant_d = 1'b1;

    lock_d = lock_q;
    case (lock_q)
      LOCK_A: if (!lockA) lock_d = LOCK_NONE;
      LOCK_B: if (!lockB) lock_d = LOCK_NONE;
      default: begin
        if (grant_a && lockA)      lock_d = LOCK_A;
        else if (grant_b && lockB) lock_d = LOCK_B;
        else                       lock_d = LOCK_NONE;
      end
    endcase

    pend_a_d     = grant_a & ~wEnA;
    pend_b_d     = grant_b & ~wEnB;
    rd_valid_a_d = pend_a_q;
    rd_valid_b_d = pend_b_q;
    rd_data_d    = (pend_a_q | pend_b_q) ? ramDataOut : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      lock_q       <= LOCK_NONE;
      last_grant_q <= 1'b1;
      pend_a_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign grantA   = grant_a;
  assign grantB   = grant_b;
  assign rdValidA = rd_valid_a_q;
  assign rdValidB = rd_valid_b_q;
  assign rdData   = rd_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random stimulus for ram_port_arbiter, checked
// against a transaction-level model (grant rules, mirror memory, return queue).
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic          reqA, reqB, wEnA, wEnB, lockA, lockB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] dataInA, dataInB;
  logic          grantA, grantB, rdValidA, rdValidB;
  logic [DW-1:0] rdData;
  logic          ramWEn;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramDataIn, ramDataOut;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .resetN(resetN),
    .reqA(reqA), .reqB(reqB), .wEnA(wEnA), .wEnB(wEnB),
    .addrA(addrA), .addrB(addrB), .dataInA(dataInA), .dataInB(dataInB),
    .lockA(lockA), .lockB(lockB), .grantA(grantA), .grantB(grantB),
    .rdValidA(rdValidA), .rdValidB(rdValidB), .rdData(rdData),
    .ramWEn(ramWEn), .ramAddr(ramAddr), .ramDataIn(ramDataIn), .ramDataOut(ramDataOut)
  );

  // Image RAM stand-in: one access per cycle, registered read data.
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ramWEn) ram_mem[ramAddr] <= ramDataIn;
    ramDataOut <= ram_mem[ramAddr];
  end

  typedef struct {
    int          due;
    bit          is_b;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_last;   // 0 = A granted last, 1 = B
  int            m_owner;  // 0 none, 1 A, 2 B
  logic [DW-1:0] m_rd_data;
  ret_t          ret_q[$];
  int            cyc, n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
  endtask

  task automatic drive_a(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit l);
    reqA = r; wEnA = w; addrA = a; dataInA = d; lockA = l;
  endtask

  task automatic drive_b(input bit r, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit l);
    reqB = r; wEnB = w; addrB = a; dataInB = d; lockB = l;
  endtask

  // One clock cycle: inputs are already applied just after a negedge.
  task automatic step();
    bit   ga, gb, ret_now;
    ret_t r;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (resetN) begin
      if (m_owner == 1)            ga = reqA;
      else if (m_owner == 2)       gb = reqB;
      else if (reqA && reqB) begin
        if (m_last == 1) ga = 1'b1;
        else             gb = 1'b1;
      end else begin
        ga = reqA;
        gb = reqB;
      end
    end
    chk("grantA", grantA, 32'(ga));
    chk("grantB", grantB, 32'(gb));
    chk("ramWEn", ramWEn, 32'(ga ? wEnA : (gb ? wEnB : 1'b0)));
    if (ga) chk("ramAddr_A", ramAddr, 32'(addrA));
    if (gb) chk("ramAddr_B", ramAddr, 32'(addrB));
    if (ga && wEnA) chk("ramDataIn_A", ramDataIn, 32'(dataInA));
    if (gb && wEnB) chk("ramDataIn_B", ramDataIn, 32'(dataInB));

    ret_now = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    if (ret_now) m_rd_data = ret_q[0].data;
    chk("rdValidA", rdValidA, 32'(ret_now && !ret_q[0].is_b));
    chk("rdValidB", rdValidB, 32'(ret_now && ret_q[0].is_b));
    chk("rdData", rdData, 32'(m_rd_data));
    if (ret_now) void'(ret_q.pop_front());

    if (!resetN) begin
      m_last    = 1;
      m_owner   = 0;
      m_rd_data = '0;
      ret_q.delete();
    end else begin
      if (ga) begin
        if (wEnA) ref_mem[addrA] = dataInA;
        else begin
          r.due = cyc + 2; r.is_b = 1'b0; r.data = ref_mem[addrA];
          ret_q.push_back(r);
        end
      end
      if (gb) begin
        if (wEnB) ref_mem[addrB] = dataInB;
        else begin
          r.due = cyc + 2; r.is_b = 1'b1; r.data = ref_mem[addrB];
          ret_q.push_back(r);
        end
      end
      if (m_owner == 1 && !lockA)      m_owner = 0;
      else if (m_owner == 2 && !lockB) m_owner = 0;
      else if (m_owner == 0) begin
        if (ga && lockA)      m_owner = 1;
        else if (gb && lockB) m_owner = 2;
      end
      if (ga) m_last = 0;
      if (gb) m_last = 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc = 0;
    m_last = 1;
    m_owner = 0;
    m_rd_data = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = DW'((i * 37 + 11) & 255);
      ref_mem[i] = DW'((i * 37 + 11) & 255);
    end

    // Reset held with both requesting and A asking for a write.
    resetN = 1'b0;
    drive_a(1, 1, 8'h44, 8'h99, 0);
    drive_b(1, 0, 8'h55, 8'h00, 0);
    @(posedge clk);
    @(negedge clk);
    repeat (3) step();

    // Contention: alternating reads, A first after reset.
    resetN = 1'b1;
    drive_a(1, 0, 8'h10, 8'h00, 0);
    drive_b(1, 0, 8'h20, 8'h00, 0);
    #1 chk("first_grant_A", grantA, 1);
    repeat (4) step();
    drive_a(0, 0, 8'h00, 8'h00, 0);
    drive_b(0, 0, 8'h00, 8'h00, 0);
    repeat (3) step();

    // Write then read of the same address.
    drive_a(1, 1, 8'h33, 8'h5A, 0);
    step();
    drive_a(1, 0, 8'h33, 8'h00, 0);
    step();
    drive_a(0, 0, 8'h00, 8'h00, 0);
    step();
    chk("wr_rd_valid", rdValidA, 1);
    chk("wr_rd_data", rdData, 32'h5A);
    step();

    // Lock: A takes ownership, B starves until lockA drops.
    drive_a(1, 0, 8'h01, 8'h00, 1);
    step();
    drive_b(1, 0, 8'h02, 8'h00, 0);
    repeat (3) step();
    drive_a(0, 0, 8'h00, 8'h00, 1);
    #1 chk("lock_idle_blocks_B", grantB, 0);
    repeat (3) step();
    drive_a(0, 0, 8'h00, 8'h00, 0);
    step();
    #1 chk("lock_release_grantB", grantB, 1);
    step();
    drive_b(0, 0, 8'h00, 8'h00, 0);
    repeat (3) step();

    // Reset while a read is in flight.
    drive_a(1, 0, 8'h05, 8'h00, 0);
    step();
    drive_a(0, 0, 8'h00, 8'h00, 0);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    repeat (3) step();
    chk("mid_reset_rdValidA", rdValidA, 0);
    chk("mid_reset_rdData", rdData, 0);

    // B streams eight reads alone.
    for (int i = 0; i < 8; i++) begin
      drive_b(1, 0, AW'(i), 8'h00, 0);
      step();
    end
    drive_b(0, 0, 8'h00, 8'h00, 0);
    repeat (3) step();

    // Random traffic on a small address window so reads hit recent writes.
    for (int i = 0; i < 400; i++) begin
      resetN = ($urandom_range(0, 63) != 0);
      drive_a($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
              AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 5) == 0);
      drive_b($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
              AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 5) == 0);
      step();
    end
    resetN = 1'b1;
    drive_a(0, 0, 8'h00, 8'h00, 0);
    drive_b(0, 0, 8'h00, 8'h00, 0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one single-port image RAM (one access per cycle, write or read, registered read data with 1-cycle latency) between requester A and requester B. Fair round-robin on contention, an optional lock for exclusive multi-cycle sequences, and per-requester tagged read-return valids. Sits directly in front of the image RAM; the RAM-side ports connect straight to the RAM instance's wEn/addr/dataIn/dataOut.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDRESS_WIDTH, 8, RAM address width
- clk  in  1  rising-edge clock
- resetN  in  1  synchronous active-low reset
- reqA / reqB  in  1  access request, held stable until granted
- wEnA / wEnB  in  1  1 = write, 0 = read
- addrA / addrB  in  ADDRESS_WIDTH  access address
- dataInA / dataInB  in  DATA_WIDTH  write data
- lockA / lockB  in  1  request exclusive ownership after this requester's next grant
- grantA / grantB  out  1  access accepted this cycle (combinational)
- rdValidA / rdValidB  out  1  rdData holds this requester's read result (one-cycle pulse)
- rdData  out  DATA_WIDTH  registered read return, shared by both requesters
- ramWEn  out  1  to RAM wEn
- ramAddr  out  ADDRESS_WIDTH  to RAM addr
- ramDataIn  out  DATA_WIDTH  to RAM dataIn
- ramDataOut  in  DATA_WIDTH  from RAM dataOut

## Operation
- State: lastGrant (0=A, 1=B), lockOwner (NONE/A/B), read-tag pipeline pend1A/pend1B, output regs rdValidA/rdValidB/rdData.
- Arbitration (combinational, evaluated only when resetN=1):
  - lockOwner=A: grantA = reqA; grantB = 0. Symmetric for B.
  - lockOwner=NONE, one request: grant it.
  - lockOwner=NONE, both requesting: grant the one not equal to lastGrant (after reset, A wins).
  - grantA and grantB never both 1.
- RAM drive: muxed from the granted requester; ramWEn = granted wEn. With no grant, ramWEn=0, ramAddr/ramDataIn = requester A's values (don't care, read side effect only).
- lastGrant <= granted requester on every grant; unchanged when idle.
- Lock: on a grant to X with lockX=1, lockOwner <= X. When lockOwner=X and lockX=0 in a cycle, lockOwner <= NONE at the next edge. Release affects arbitration starting the following cycle. An idle owner holding lockX=1 blocks the other requester indefinitely (intended).
- Read return: pend1X <= grantX & ~wEnX. Next cycle: rdValidX <= pend1X; if pend1A|pend1B, rdData <= ramDataOut; otherwise rdData holds.
- Writes produce no return. Access order at the RAM equals grant order, so a write followed by a read of the same address returns the written data.

## Timing
- Reset (resetN=0 at an edge): lastGrant=B (A first), lockOwner=NONE, pend1A/B=0, rdValidA/B=0, rdData=0. While resetN=0: grantA/B=0, ramWEn=0.
- Reset mid-operation discards in-flight reads: no rdValid pulse after reset.
- Throughput: one access per cycle. Back-to-back reads from alternating requesters return in order.
- Read latency: grant in cycle N, RAM data in cycle N+1, rdValidX/rdData valid in cycle N+2.
- Requester handshake: the access completes in the cycle grantX=1. The requester may change addr/data or drop req in the next cycle.

## Test plan
- Reset: hold resetN=0 with reqA=reqB=1, wEnA=1 -> grantA/B=0, ramWEn=0. Release -> first grant goes to A; rdValid stays 0 for 3 cycles.
- Contention: reqA=reqB=1 (reads, addr 0x10/0x20) for 4 cycles -> grants A,B,A,B. rdValidA,rdValidB alternate starting 2 cycles after the first grant, each with the RAM contents of its own address.
- Write-then-read: A writes 0x5A to 0x33, then reads 0x33 in the next cycle -> rdValidA with rdData=0x5A, 2 cycles after the read grant.
- Lock: A granted with lockA=1, B requesting -> B gets no grant while lockA=1 (including idle A cycles). lockA drops in cycle K -> B granted in cycle K+1.
- Reset mid-read: read granted in cycle N, resetN=0 at edge N+1 -> no rdValidA, rdData=0.
- Single requester streaming: reqB=1 for 8 reads at addr 0..7, reqA=0 -> grantB every cycle, 8 consecutive rdValidB pulses returning mem[0..7] in order.
